tomasulo_rob: RTL and testbench

- Reorder buffer for the Tomasulo core, sitting between the issue stage and the register bank.
- The issue stage allocates one in-order entry per dispatched instruction and receives that entry's tag.
- Reservation stations broadcast results on the CDB. The ROB captures each result against its tag, serves operand lookups from the issue stage, and retires the head entry in program order into the register bank.

---
 rtl/tomasulo_pkg.sv | 25 ++
 rtl/tomasulo_rob_lookup.sv | 42 ++++
 rtl/tomasulo_rob.sv | 164 ++++++++++++++++
 tb/tb_tomasulo_rob.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// ============================================================================
// tomasulo_pkg : shared ROB constants, tag type and entry record
// Revision     : 1.0
// ============================================================================
`default_nettype none

package tomasulo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int REG_W     = 4;
  localparam int DATA_W    = 16;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/tomasulo_rob_lookup.sv
// ============================================================================
// tomasulo_rob_lookup : one operand lookup port with same-cycle CDB bypass
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tomasulo_rob_lookup #(
  parameter int DEPTH  = tomasulo_pkg::ROB_DEPTH,
  parameter int TAG_W  = tomasulo_pkg::ROB_TAG_W,
  parameter int DATA_W = tomasulo_pkg::DATA_W
) (
  input  logic [TAG_W-1:0]        q_tag,
  input  logic                    cdb_valid,
  input  logic [TAG_W-1:0]        cdb_tag,
  input  logic [DATA_W-1:0]       cdb_value,
  input  logic [DEPTH-1:0]        busy_vec,
  input  logic [DEPTH-1:0]        ready_vec,
  input  logic [DEPTH*DATA_W-1:0] value_vec,
  output logic                    q_ready,
  output logic [DATA_W-1:0]       q_value
);

  import tomasulo_pkg::*;

  // A broadcast for a busy entry wins over whatever the entry holds now.
  always_comb begin
    q_ready = 1'b0;
    q_value = '0;
    if (busy_vec[q_tag]) begin
      if (cdb_valid && (cdb_tag == q_tag)) begin
        q_ready = 1'b1;
        q_value = cdb_value;
      end else begin
        q_ready = ready_vec[q_tag];
        q_value = value_vec[q_tag*DATA_W +: DATA_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tomasulo_rob.sv
// ============================================================================
// tomasulo_rob : in-order reorder buffer with CDB capture and operand lookup
//                optional squash port enabled by TOMASULO_ROB_FLUSH_EN
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tomasulo_rob #(
  parameter int DEPTH  = tomasulo_pkg::ROB_DEPTH,
  parameter int TAG_W  = tomasulo_pkg::ROB_TAG_W,
  parameter int REG_W  = tomasulo_pkg::REG_W,
  parameter int DATA_W = tomasulo_pkg::DATA_W
) (
  input  logic              clk1,
  input  logic              rst_n,
`ifdef TOMASULO_ROB_FLUSH_EN
  input  logic              flush_valid,
`endif
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic [TAG_W-1:0]  q1_tag,
  output logic              q1_ready,
  output logic [DATA_W-1:0] q1_value,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q2_value,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_value,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  import tomasulo_pkg::*;

  // Entries are stored as the shared record, so widths must agree with it.
  generate
    if ((REG_W != tomasulo_pkg::REG_W) || (DATA_W != tomasulo_pkg::DATA_W) ||
        (DEPTH != (1 << TAG_W))) begin : g_param_check
      $error("tomasulo_rob: parameters inconsistent with tomasulo_pkg");
    end
  endgenerate

  rob_entry_t        rob [DEPTH];
  logic [TAG_W-1:0]  head_p;
  logic [TAG_W-1:0]  tail_p;
  logic [TAG_W:0]    count_r;
  logic              flush;
  logic              head_done;
  logic              do_alloc;

`ifdef TOMASULO_ROB_FLUSH_EN
  assign flush = flush_valid;
`else
  assign flush = 1'b0;
`endif

  // Full means no allocation, even if the head retires at this same edge.
  assign alloc_ready  = (count_r != (TAG_W+1)'(DEPTH)) && !flush;
  assign alloc_tag    = tail_p;
  assign do_alloc     = alloc_valid && alloc_ready;

  assign head_done    = rob[head_p].busy && rob[head_p].ready;
  assign commit_valid = head_done && !flush;
  assign commit_tag   = head_p;
  assign commit_dest  = rob[head_p].dest;
  assign commit_value = rob[head_p].value;

  assign count = count_r;
  assign empty = (count_r == '0);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob[i] <= '0;
      end
      head_p  <= '0;
      tail_p  <= '0;
      count_r <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob[i].busy  <= 1'b0;
        rob[i].ready <= 1'b0;
      end
      tail_p  <= head_p;
      count_r <= '0;
    end else begin
      // Busy is sampled before this edge, so a tag being allocated now is skipped.
      if (cdb_valid && rob[cdb_tag].busy) begin
        rob[cdb_tag].ready <= 1'b1;
        rob[cdb_tag].value <= cdb_value;
      end
      if (commit_valid) begin
        rob[head_p].busy  <= 1'b0;
        rob[head_p].ready <= 1'b0;
        head_p            <= head_p + 1'b1;
      end
      if (do_alloc) begin
        rob[tail_p].busy  <= 1'b1;
        rob[tail_p].ready <= 1'b0;
        rob[tail_p].dest  <= alloc_dest;
        tail_p            <= tail_p + 1'b1;
      end
      case ({do_alloc, commit_valid})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  logic [DEPTH-1:0]        busy_vec;
  logic [DEPTH-1:0]        ready_vec;
  logic [DEPTH*DATA_W-1:0] value_vec;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign busy_vec[g]                    = rob[g].busy;
      assign ready_vec[g]                   = rob[g].ready;
      assign value_vec[g*DATA_W +: DATA_W]  = rob[g].value;
    end
  endgenerate

  tomasulo_rob_lookup #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_lookup_q1 (
    .q_tag     (q1_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .busy_vec  (busy_vec),
    .ready_vec (ready_vec),
    .value_vec (value_vec),
    .q_ready   (q1_ready),
    .q_value   (q1_value)
  );

  tomasulo_rob_lookup #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_lookup_q2 (
    .q_tag     (q2_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .busy_vec  (busy_vec),
    .ready_vec (ready_vec),
    .value_vec (value_vec),
    .q_ready   (q2_ready),
    .q_value   (q2_value)
  );

endmodule

`default_nettype wire

// File: tb/tb_tomasulo_rob.sv
// ============================================================================
// tb_tomasulo_rob : directed self-checking bench for tomasulo_rob
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_tomasulo_rob;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;
  localparam int REG_W  = 4;
  localparam int DATA_W = 16;

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic              flush_valid;
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic [TAG_W-1:0]  q1_tag;
  logic              q1_ready;
  logic [DATA_W-1:0] q1_value;
  logic [TAG_W-1:0]  q2_tag;
  logic              q2_ready;
  logic [DATA_W-1:0] q2_value;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic [REG_W-1:0]  commit_dest;
  logic [DATA_W-1:0] commit_value;
  logic [TAG_W:0]    count;
  logic              empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk1 = ~clk1;

  tomasulo_rob #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .REG_W  (REG_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
`ifdef TOMASULO_ROB_FLUSH_EN
    .flush_valid  (flush_valid),
`endif
    .alloc_valid  (alloc_valid),
    .alloc_dest   (alloc_dest),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .q1_tag       (q1_tag),
    .q1_ready     (q1_ready),
    .q1_value     (q1_value),
    .q2_tag       (q2_tag),
    .q2_ready     (q2_ready),
    .q2_value     (q2_value),
    .commit_valid (commit_valid),
    .commit_tag   (commit_tag),
    .commit_dest  (commit_dest),
    .commit_value (commit_value),
    .count        (count),
    .empty        (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic apply_reset();
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
    flush_valid = 1'b0;
    rst_n       = 1'b0;
    #2;
    rst_n       = 1'b1;
    #1;
  endtask

  task automatic cdb_write(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_value = v;
    tick();
    cdb_valid = 1'b0;
    #1;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = REG_W'(i + 1);
      #1;
      check($sformatf("alloc_tag_%0d", i), 32'(alloc_tag), 32'(i));
      tick();
    end
    alloc_valid = 1'b0;
    #1;
  endtask

  logic [DATA_W-1:0] ooo_val [3];
  logic [REG_W-1:0]  ooo_dst [3];

  initial begin
    rst_n       = 1'b0;
    flush_valid = 1'b0;
    alloc_valid = 1'b0;
    alloc_dest  = '0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    cdb_value   = '0;
    q1_tag      = '0;
    q2_tag      = '0;
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_alloc_tag",   32'(alloc_tag),   32'd0);
    check("rst_empty",       32'(empty),       32'd1);
    check("rst_count",       32'(count),       32'd0);
    check("rst_commit",      32'(commit_valid),32'd0);
    check("rst_q1_ready",    32'(q1_ready),    32'd0);

    // Single allocate, complete, retire
    alloc_valid = 1'b1;
    alloc_dest  = 4'd5;
    tick();
    alloc_valid = 1'b0;
    #1;
    check("one_count",     32'(count),        32'd1);
    check("one_alloc_tag", 32'(alloc_tag),    32'd1);
    check("one_no_commit", 32'(commit_valid), 32'd0);
    cdb_valid = 1'b1;
    cdb_tag   = 3'd0;
    cdb_value = 16'h0033;
    q1_tag    = 3'd0;
    #1;
    check("one_bypass_rdy", 32'(q1_ready), 32'd1);
    check("one_bypass_val", 32'(q1_value), 32'h33);
    tick();
    cdb_valid = 1'b0;
    #1;
    check("one_commit_valid", 32'(commit_valid), 32'd1);
    check("one_commit_tag",   32'(commit_tag),   32'd0);
    check("one_commit_dest",  32'(commit_dest),  32'd5);
    check("one_commit_value", 32'(commit_value), 32'h33);
    tick();
    check("one_empty_after", 32'(empty),        32'd1);
    check("one_count_after", 32'(count),        32'd0);
    check("one_commit_off",  32'(commit_valid), 32'd0);

    // Out-of-order completion, in-order retirement
    apply_reset();
    check("midrst_empty", 32'(empty), 32'd1);
    alloc_n(3);
    cdb_write(3'd2, 16'd7);
    check("ooo_hold", 32'(commit_valid), 32'd0);
    q2_tag = 3'd2;
    #1;
    check("ooo_q2_ready", 32'(q2_ready), 32'd1);
    check("ooo_q2_value", 32'(q2_value), 32'd7);
    cdb_write(3'd1, 16'd9);
    check("ooo_hold2", 32'(commit_valid), 32'd0);
    cdb_write(3'd0, 16'd4);
    ooo_val[0] = 16'd4; ooo_val[1] = 16'd9; ooo_val[2] = 16'd7;
    ooo_dst[0] = 4'd1;  ooo_dst[1] = 4'd2;  ooo_dst[2] = 4'd3;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ooo_cv_%0d", i),  32'(commit_valid), 32'd1);
      check($sformatf("ooo_tag_%0d", i), 32'(commit_tag),   32'(i));
      check($sformatf("ooo_dst_%0d", i), 32'(commit_dest),  32'(ooo_dst[i]));
      check($sformatf("ooo_val_%0d", i), 32'(commit_value), 32'(ooo_val[i]));
      tick();
    end
    check("ooo_empty", 32'(empty), 32'd1);

    // Fill to capacity
    apply_reset();
    alloc_n(8);
    check("full_count", 32'(count),       32'd8);
    check("full_ready", 32'(alloc_ready), 32'd0);
    check("full_tag",   32'(alloc_tag),   32'd0);

    // Same-cycle CDB bypass on both lookup ports, then no bypass
    q1_tag    = 3'd3;
    q2_tag    = 3'd3;
    cdb_valid = 1'b1;
    cdb_tag   = 3'd3;
    cdb_value = 16'h00AA;
    #1;
    check("byp_q1_ready", 32'(q1_ready), 32'd1);
    check("byp_q1_value", 32'(q1_value), 32'hAA);
    check("byp_q2_ready", 32'(q2_ready), 32'd1);
    cdb_valid = 1'b0;
    #1;
    check("byp_gone", 32'(q1_ready), 32'd0);

    // Full ROB committing this cycle still refuses allocation
    cdb_write(3'd0, 16'h0011);
    check("fc_commit", 32'(commit_valid), 32'd1);
    check("fc_value",  32'(commit_value), 32'h11);
    check("fc_refuse", 32'(alloc_ready),  32'd0);
    alloc_valid = 1'b1;
    alloc_dest  = 4'hC;
    tick();
    check("fc_count7", 32'(count),       32'd7);
    check("fc_ready",  32'(alloc_ready), 32'd1);
    check("fc_tag0",   32'(alloc_tag),   32'd0);
    tick();
    alloc_valid = 1'b0;
    #1;
    check("fc_count8", 32'(count),        32'd8);
    check("fc_wrap",   32'(alloc_tag),    32'd1);
    check("fc_full",   32'(alloc_ready),  32'd0);
    check("fc_head1",  32'(commit_valid), 32'd0);

    // Ignored CDB writes (non-busy / being allocated) and overwrite
    apply_reset();
    cdb_write(3'd0, 16'h0055);
    alloc_valid = 1'b1;
    alloc_dest  = 4'd2;
    cdb_valid   = 1'b1;
    cdb_tag     = 3'd1;
    cdb_value   = 16'h0099;
    tick();
    alloc_dest  = 4'd3;
    cdb_value   = 16'h0077;
    tick();
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
    q1_tag      = 3'd0;
    q2_tag      = 3'd1;
    #1;
    check("ign_q1_ready", 32'(q1_ready),     32'd0);
    check("ign_q2_ready", 32'(q2_ready),     32'd0);
    check("ign_commit",   32'(commit_valid), 32'd0);
    check("ign_count",    32'(count),        32'd2);
    cdb_write(3'd1, 16'h0066);
    cdb_write(3'd1, 16'h0077);
    check("ovw_ready", 32'(q2_ready),     32'd1);
    check("ovw_value", 32'(q2_value),     32'h77);
    check("ovw_hold",  32'(commit_valid), 32'd0);
    q1_tag = 3'd5;
    #1;
    check("nb_ready", 32'(q1_ready), 32'd0);
    check("nb_value", 32'(q1_value), 32'd0);

`ifdef TOMASULO_ROB_FLUSH_EN
    // Flush beats allocate, CDB write and commit at the same edge
    apply_reset();
    alloc_n(5);
    cdb_write(3'd0, 16'h0001);
    check("fl_pre_count",  32'(count),        32'd5);
    check("fl_pre_commit", 32'(commit_valid), 32'd1);
    flush_valid = 1'b1;
    alloc_valid = 1'b1;
    alloc_dest  = 4'd9;
    cdb_valid   = 1'b1;
    cdb_tag     = 3'd2;
    cdb_value   = 16'h0042;
    #1;
    check("fl_commit_off", 32'(commit_valid), 32'd0);
    check("fl_alloc_off",  32'(alloc_ready),  32'd0);
    tick();
    flush_valid = 1'b0;
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
    q1_tag      = 3'd2;
    q2_tag      = 3'd0;
    #1;
    check("fl_count",  32'(count),        32'd0);
    check("fl_empty",  32'(empty),        32'd1);
    check("fl_tail",   32'(alloc_tag),    32'd0);
    check("fl_commit", 32'(commit_valid), 32'd0);
    check("fl_q1",     32'(q1_ready),     32'd0);
    check("fl_q2",     32'(q2_ready),     32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
